// File: rtl/track_occupancy_detector.sv
// Axle-counter section detector feeding train_detect of the crossing controller.
// Two raw axle sensors are synchronized and debounced; their rising edges count
// axles into and out of the section. Any fault latches train_detect high.
// Optional feature: define TRACK_HOLDOFF_EN to add a HOLD state (state_o=3)
// that keeps train_detect high for HOLD_CYCLES after the count reaches zero.
module track_occupancy_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sens_entry,
    input  logic             sens_exit,
    output logic             train_detect,
    output logic [CNT_W-1:0] axle_count,
    output logic             fault,
    output logic [1:0]       state_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Reject parameter values outside the supported range at elaboration
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || TIMEOUT_CYCLES < 1 ||
        HOLD_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("track_occupancy_detector: parameter out of range");
    end

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        OCCUPIED = 2'd1,
        FAULT    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Index 0 = entry sensor, index 1 = exit sensor
    logic [1:0]      sync1, sync2, deb, deb_d, pulse;
    logic [DB_W-1:0] db_cnt [2];

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [TMO_W-1:0] tmo, tmo_next;
    logic             td_next, fault_next;
    logic             in_p, out_p;

`ifdef TRACK_HOLDOFF_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    logic [HOLD_W-1:0] hold_cnt, hold_next;
`endif

    assign in_p       = pulse[0];
    assign out_p      = pulse[1];
    assign axle_count = cnt;
    assign state_o    = state;

    // Synchronize, debounce and register one-cycle rising-edge pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_d     <= '0;
            pulse     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {sens_exit, sens_entry};
            sync2 <= sync1;
            deb_d <= deb;
            pulse <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CLEAR;
            cnt          <= '0;
            tmo          <= '0;
            train_detect <= 1'b0;
            fault        <= 1'b0;
`ifdef TRACK_HOLDOFF_EN
            hold_cnt     <= '0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            tmo          <= tmo_next;
            train_detect <= td_next;
            fault        <= fault_next;
`ifdef TRACK_HOLDOFF_EN
            hold_cnt     <= hold_next;
`endif
        end
    end

    // Next-state, axle count and timeout logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tmo_next   = tmo;
`ifdef TRACK_HOLDOFF_EN
        hold_next  = hold_cnt;
`endif
        case (state)
            CLEAR: begin
                if (in_p && !out_p) begin
                    state_next = OCCUPIED;
                    cnt_next   = cnt + CNT_W'(1);
                    tmo_next   = '0;
                end else if (out_p && !in_p) begin
                    state_next = FAULT;
                end
            end
            OCCUPIED: begin
                if (in_p && out_p) begin
                    tmo_next = '0;
                end else if (in_p) begin
                    tmo_next = '0;
                    if (cnt == CNT_MAX) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else if (out_p) begin
                    tmo_next = '0;
                    if (cnt == '0) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
`ifdef TRACK_HOLDOFF_EN
                            state_next = HOLD;
                            hold_next  = '0;
`else
                            state_next = CLEAR;
`endif
                        end
                    end
                end else if (tmo == TMO_LAST) begin
                    state_next = FAULT;
                end else begin
                    tmo_next = tmo + TMO_W'(1);
                end
            end
`ifdef TRACK_HOLDOFF_EN
            HOLD: begin
                if (in_p && !out_p) begin
                    state_next = OCCUPIED;
                    cnt_next   = CNT_W'(1);
                    tmo_next   = '0;
                end else if (out_p && !in_p) begin
                    state_next = FAULT;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = CLEAR;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
`endif
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    // Output decode from the next state so the outputs are registered with it
    always_comb begin
        td_next    = (state_next != CLEAR);
        fault_next = (state_next == FAULT);
    end

endmodule

// File: tb/tb_track_occupancy_detector.sv
module tb_track_occupancy_detector;

`ifdef TRACK_HOLDOFF_EN
    localparam int HOLD_ON = 1;
`else
    localparam int HOLD_ON = 0;
`endif
    localparam int HN = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sens_entry = 1'b0;
    logic       sens_exit = 1'b0;
    logic       td, flt, td2, flt2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [1:0] st, st2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          dut;
        logic [11:0] val;
        string       tag;
    } exp_t;
    exp_t sbq[$];

    logic [11:0] h_obs [HN][2];

    track_occupancy_detector dut (
        .clk(clk), .reset(reset), .sens_entry(sens_entry), .sens_exit(sens_exit),
        .train_detect(td), .axle_count(cnt), .fault(flt), .state_o(st)
    );

    track_occupancy_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .sens_entry(sens_entry), .sens_exit(sens_exit),
        .train_detect(td2), .axle_count(cnt2), .fault(flt2), .state_o(st2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] pk(input int c, input logic t, input logic f, input int s);
        return {8'(c), t, f, 2'(s)};
    endfunction

    // Record what both DUTs show after every active edge
    always @(negedge clk) begin
        if (cyc < HN) begin
            h_obs[cyc][0] = pk(int'(cnt), td, flt, int'(st));
            h_obs[cyc][1] = pk(int'(cnt2), td2, flt2, int'(st2));
        end
    end

    task automatic push(input int c, input int d, input logic [11:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.val = v;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sens_entry = 1'b0;
        sens_exit = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start(input logic ent, input logic ext, output int c);
        @(negedge clk);
        sens_entry = ent;
        sens_exit = ext;
        c = cyc;
    endtask

    task automatic pulse_end();
        repeat (6) @(negedge clk);
        sens_entry = 1'b0;
        sens_exit = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        int c;
        logic [11:0] o;
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            pulse_start(1'b1, 1'b0, c);
            push(c + 8, 0, pk(i, 1'b1, 1'b0, 1), "reset_prefill");
            pulse_end();
        end
        repeat (2) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
        // Asynchronous reset mid-train discards the count immediately
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({cnt, td, flt, st} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got cnt=%0d td=%0b fault=%0b st=%0d, want all 0", cnt, td, flt, st);
        end
        checks++;
        if ({cnt2, td2, flt2, st2} !== 6'h00) begin
            errors++;
            $display("FAIL reset_async_w2: got cnt=%0d td=%0b fault=%0b st=%0d, want all 0", cnt2, td2, flt2, st2);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({cnt, td, flt, st} !== 12'h000) begin
            errors++;
            $display("FAIL reset_release: got cnt=%0d td=%0b fault=%0b st=%0d, want all 0", cnt, td, flt, st);
        end
    endtask

    task automatic test_count();
        int c;
        logic [11:0] o;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            pulse_start(1'b1, 1'b0, c);
            push(c + 7, 0, pk(i - 1, i > 1, 1'b0, (i > 1) ? 1 : 0), "count_in_pre");
            push(c + 8, 0, pk(i, 1'b1, 1'b0, 1), "count_in_post");
            pulse_end();
        end
        for (int i = 1; i <= 4; i++) begin
            pulse_start(1'b0, 1'b1, c);
            push(c + 7, 0, pk(5 - i, 1'b1, 1'b0, 1), "count_out_pre");
            if (i < 4)
                push(c + 8, 0, pk(4 - i, 1'b1, 1'b0, 1), "count_out_post");
            else
                push(c + 8, 0, pk(0, HOLD_ON != 0, 1'b0, HOLD_ON * 3), "count_out_zero");
            pulse_end();
        end
        repeat (2) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
    endtask

    task automatic test_glitch();
        int c;
        logic [11:0] o;
        do_reset();
        @(negedge clk);
        c = cyc;
        for (int k = 1; k <= 30; k++) push(c + k, 0, pk(0, 1'b0, 1'b0, 0), "glitch_ignored");
        sens_entry = 1'b1;
        repeat (3) @(negedge clk);
        sens_entry = 1'b0;
        repeat (8) @(negedge clk);
        sens_entry = 1'b1;
        repeat (2) @(negedge clk);
        sens_entry = 1'b0;
        repeat (20) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
    endtask

    task automatic test_aligned_underflow();
        int c;
        logic [11:0] o;
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            pulse_start(1'b1, 1'b0, c);
            push(c + 8, 0, pk(i, 1'b1, 1'b0, 1), "aligned_fill");
            pulse_end();
        end
        pulse_start(1'b1, 1'b1, c);
        push(c + 8, 0, pk(2, 1'b1, 1'b0, 1), "aligned_net_zero");
        push(c + 11, 0, pk(2, 1'b1, 1'b0, 1), "aligned_settled");
        pulse_end();
        for (int i = 1; i <= 2; i++) begin
            pulse_start(1'b0, 1'b1, c);
            if (i == 1)
                push(c + 8, 0, pk(1, 1'b1, 1'b0, 1), "aligned_drain");
            else
                push(c + 8, 0, pk(0, HOLD_ON != 0, 1'b0, HOLD_ON * 3), "aligned_drain_zero");
            pulse_end();
        end
        repeat (20) @(negedge clk);
        pulse_start(1'b0, 1'b1, c);
        push(c + 7, 0, pk(0, 1'b0, 1'b0, 0), "underflow_pre");
        push(c + 8, 0, pk(0, 1'b1, 1'b1, 2), "underflow_fault");
        push(c + 11, 0, pk(0, 1'b1, 1'b1, 2), "underflow_sticky");
        pulse_end();
        repeat (2) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({cnt, td, flt, st} !== 12'h000) begin
            errors++;
            $display("FAIL fault_reset: got cnt=%0d td=%0b fault=%0b st=%0d, want all 0", cnt, td, flt, st);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_timeout();
        int c, c2;
        logic [11:0] o;
        do_reset();
        pulse_start(1'b1, 1'b0, c);
        push(c + 8, 0, pk(1, 1'b1, 1'b0, 1), "timeout_enter");
        push(c + 1007, 0, pk(1, 1'b1, 1'b0, 1), "timeout_pre");
        push(c + 1008, 0, pk(1, 1'b1, 1'b1, 2), "timeout_fault");
        push(c + 1030, 0, pk(1, 1'b1, 1'b1, 2), "timeout_sticky");
        pulse_end();
        while (cyc < c + 1032) @(negedge clk);
        // Sensor activity after the fault must not move the frozen count
        pulse_start(1'b0, 1'b1, c2);
        push(c2 + 10, 0, pk(1, 1'b1, 1'b1, 2), "timeout_frozen");
        pulse_end();
        repeat (2) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
    endtask

    task automatic test_overflow();
        int c;
        logic [11:0] o;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            pulse_start(1'b1, 1'b0, c);
            push(c + 8, 0, pk(i, 1'b1, 1'b0, 1), "overflow_wide");
            if (i < 4) begin
                push(c + 8, 1, pk(i, 1'b1, 1'b0, 1), "overflow_fill");
            end else begin
                push(c + 7, 1, pk(3, 1'b1, 1'b0, 1), "overflow_pre");
                push(c + 8, 1, pk(3, 1'b1, 1'b1, 2), "overflow_sat");
            end
            pulse_end();
        end
        repeat (2) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
    endtask

`ifdef TRACK_HOLDOFF_EN
    task automatic test_holdoff();
        int c, ez, ce;
        logic [11:0] o;
        do_reset();
        pulse_start(1'b1, 1'b0, c);
        pulse_end();
        pulse_start(1'b0, 1'b1, c);
        ez = c + 8;
        push(ez, 0, pk(0, 1'b1, 1'b0, 3), "hold_enter");
        push(ez + 15, 0, pk(0, 1'b1, 1'b0, 3), "hold_last");
        push(ez + 16, 0, pk(0, 1'b0, 1'b0, 0), "hold_clear");
        pulse_end();
        repeat (16) @(negedge clk);
        pulse_start(1'b1, 1'b0, c);
        pulse_end();
        pulse_start(1'b0, 1'b1, c);
        ez = c + 8;
        repeat (6) @(negedge clk);
        sens_exit = 1'b0;
        while (cyc < ez) @(negedge clk);
        sens_entry = 1'b1;
        ce = cyc;
        push(ce + 7, 0, pk(0, 1'b1, 1'b0, 3), "hold_reentry_pre");
        push(ce + 8, 0, pk(1, 1'b1, 1'b0, 1), "hold_reentry");
        push(ce + 20, 0, pk(1, 1'b1, 1'b0, 1), "hold_reentry_stay");
        repeat (6) @(negedge clk);
        sens_entry = 1'b0;
        repeat (18) @(negedge clk);
        while (sbq.size() != 0) begin
            exp_t e = sbq.pop_front();
            checks++;
            if (e.cyc >= cyc || e.cyc >= HN) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled", e.tag, e.cyc);
            end else if (h_obs[e.cyc][e.dut] !== e.val) begin
                o = h_obs[e.cyc][e.dut];
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got cnt=%0d td=%0b fault=%0b st=%0d, want cnt=%0d td=%0b fault=%0b st=%0d",
                         e.tag, e.dut, e.cyc, o[11:4], o[3], o[2], o[1:0], e.val[11:4], e.val[3], e.val[2], e.val[1:0]);
            end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got time %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_count();
        test_glitch();
        test_aligned_underflow();
        test_timeout();
        test_overflow();
`ifdef TRACK_HOLDOFF_EN
        test_holdoff();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/track_occupancy_detector.md
Name: track_occupancy_detector

Overview:
- Axle-counter section detector that produces the `train_detect` input of the crossing controller, so it is the driving end of that link.
- Monitors two raw track sensors: an entry sensor upstream of the crossing and an exit sensor downstream.
- Counts axles into and out of the section; reports the section occupied while any axle remains inside.
- Fail-safe: any fault forces `train_detect` high.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized sensor level must hold before it is accepted (1..255).
- CNT_W, 8, width of the axle counter.
- TIMEOUT_CYCLES, 1000, maximum cycles in OCCUPIED with no accepted sensor edge before declaring a fault.
- HOLD_CYCLES, 16, extra occupied time after the count returns to zero (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sens_entry  input  1  raw entry axle sensor, asynchronous; high while a wheel is over it.
- sens_exit  input  1  raw exit axle sensor, asynchronous; high while a wheel is over it.
- train_detect  output  1  section occupied or faulted; drives the crossing controller.
- axle_count  output  CNT_W  axles currently inside the section.
- fault  output  1  sticky fault flag.
- state_o  output  2  current FSM state (CLEAR=0, OCCUPIED=1, FAULT=2).

Behaviour:
- Reset (asynchronous, active-high): synchronizers, debounced levels and all counters clear to 0. State = CLEAR, train_detect=0, axle_count=0, fault=0. Reset asserted mid-train discards the count.
- Input conditioning:
  - Each sensor passes through a 2-flop synchronizer.
  - The debounced level toggles only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch gap restarts the debounce count.
  - A pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge pulses:
  - in_p = rising edge of debounced entry; out_p = rising edge of debounced exit.
  - Both pulses are one cycle wide.
- Latency: a clean raw rise first sampled at edge N updates axle_count and train_detect at edge N+3+DEBOUNCE_CYCLES (7 with default parameters). Falling edges of the raw sensors cause no count change.
- Counter update, at each clock edge:
  - in_p only: +1.
  - out_p only: -1.
  - in_p and out_p in the same cycle: net change 0, no fault.
  - Outside FAULT, the count only moves by these rules.
- FSM transitions:
  - CLEAR -> OCCUPIED on in_p.
  - CLEAR with out_p only: underflow -> FAULT.
  - OCCUPIED -> CLEAR on the cycle the count reaches 0.
  - OCCUPIED -> FAULT on underflow (out_p with count 0 and no in_p).
  - OCCUPIED -> FAULT on overflow (in_p with count = 2^CNT_W-1 and no out_p); the count saturates at max.
  - OCCUPIED -> FAULT when the timeout counter reaches TIMEOUT_CYCLES. The timeout counter clears on any in_p/out_p and on entering OCCUPIED.
  - FAULT is absorbing; only reset leaves it.
- Outputs:
  - train_detect = 1 in OCCUPIED and FAULT, 0 in CLEAR. It is registered and glitch-free.
  - fault = 1 only in FAULT.
  - axle_count freezes at its value on fault entry.

Optional Feature:
- Macro `TRACK_HOLDOFF_EN`.
- Defined:
  - The OCCUPIED -> CLEAR transition passes through a HOLD state (state_o=3) for HOLD_CYCLES cycles with train_detect=1.
  - in_p during HOLD returns to OCCUPIED with count 1 and cancels the hold.
  - out_p during HOLD -> FAULT (underflow).
  - Timeout is not checked in HOLD.
- Undefined: no HOLD state exists; train_detect falls on the same edge axle_count reaches 0. state_o value 3 never occurs.

Test Plan:
- Reset, then 4 entry pulses (6 cycles high, 6 low), then 4 exit pulses -> axle_count steps 1,2,3,4 then 3..0. train_detect rises 7 cycles after the first raw entry rise and falls on the edge count hits 0. fault=0 throughout.
- Entry glitch of 3 cycles, then 2 cycles (DEBOUNCE_CYCLES=4) -> no count change, train_detect stays 0.
- Entry and exit pulses aligned with count=2 -> count stays 2, no fault. Then an exit pulse from CLEAR -> fault=1, state_o=2, train_detect=1 after next reset-free cycles; reset -> all outputs 0.
- One entry pulse, then no activity for 1000 cycles -> fault asserts on the cycle the timeout counter hits 1000, train_detect stays 1, axle_count=1 frozen.
- CNT_W=2: 4 entry pulses -> count saturates at 3, fault=1 on the 4th.
- With TRACK_HOLDOFF_EN: 1 in, 1 out -> train_detect stays high 16 cycles after count=0. Repeat with an entry pulse at hold cycle 8 -> state returns to OCCUPIED, count=1.
